// File: rtl/adc_capture_driver.sv
// Triggered capture-and-average engine: accumulates ADC beats over 2^shift triggers
// and streams the averaged record out as 32-bit words (two 16-bit samples per word).
module adc_capture_driver #(
    parameter int MEM_DEPTH     = 16,
    parameter int CFG_W         = 16,
    parameter int TRIG_BIT      = 0,
    parameter int SDATA_BIT     = 1,
    parameter int CYC_CLK_BIT   = 2,
    parameter int SHIFT_CLK_BIT = 3
) (
    input  logic         pl_clk,
    input  logic         rst,
    input  logic [15:0]  gpio_ctrl,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    input  logic         select_in
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = AW + 3;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctl_raw, ctl_s1_q, ctl_s2_q, ctl_prev_q, ctl_rise;
    logic             sel_s1_q, sel_s2_q;
    logic             unused_gpio;
    logic [CFG_W-1:0] run_cycles_q, shift_val_q;
    logic [CW-1:0]    eff_cycles_cfg, eff_cycles_q;
    logic [3:0]       eff_shift_cfg, eff_shift_q;
    logic [AW-1:0]    beat_idx_q, rd_addr;
    logic [8:0]       trig_cnt_q;
    logic [KW-1:0]    ld_k_q, ld_k_d, total_words;
    logic             prime_q, ld;
    logic             beat_fire, last_beat, set_done, word_fire, last_word;
    logic [31:0]      m_tdata_q, out_word;
    logic             m_tvalid_q;
    logic             acc_vld_q, acc_first_q;
    logic [AW-1:0]    acc_idx_q;
    logic [127:0]     acc_data_q;
    logic [191:0]     rd_q, wr_row;
    logic [191:0]     mem [MEM_DEPTH];
    logic [15:0]      lane_avg [8];

    // Bit order inside ctl_*: trigger, serial data, cycles clock, shift clock
    assign ctl_raw     = {gpio_ctrl[SHIFT_CLK_BIT], gpio_ctrl[CYC_CLK_BIT],
                          gpio_ctrl[SDATA_BIT], gpio_ctrl[TRIG_BIT]};
    assign unused_gpio = ^gpio_ctrl;
    assign ctl_rise    = ctl_s2_q & ~ctl_prev_q;

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            ctl_s1_q   <= '0;
            ctl_s2_q   <= '0;
            ctl_prev_q <= '0;
            sel_s1_q   <= 1'b0;
            sel_s2_q   <= 1'b0;
        end else begin
            ctl_s1_q   <= ctl_raw;
            ctl_s2_q   <= ctl_s1_q;
            ctl_prev_q <= ctl_s2_q;
            sel_s1_q   <= select_in;
            sel_s2_q   <= sel_s1_q;
        end
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            run_cycles_q <= CFG_W'(1);
            shift_val_q  <= '0;
        end else begin
            if (sel_s2_q && ctl_rise[2]) run_cycles_q <= {ctl_s2_q[1], run_cycles_q[CFG_W-1:1]};
            if (sel_s2_q && ctl_rise[3]) shift_val_q  <= {ctl_s2_q[1], shift_val_q[CFG_W-1:1]};
        end
    end

    always_comb begin
        if (run_cycles_q == '0)                     eff_cycles_cfg = CW'(1);
        else if (run_cycles_q > CFG_W'(MEM_DEPTH))  eff_cycles_cfg = CW'(MEM_DEPTH);
        else                                        eff_cycles_cfg = run_cycles_q[CW-1:0];
        eff_shift_cfg = (shift_val_q > CFG_W'(8)) ? 4'd8 : shift_val_q[3:0];
    end

    assign beat_fire   = (state_q == S_CAPTURE) && s_axis_tvalid;
    assign last_beat   = beat_fire && (CW'(beat_idx_q) == eff_cycles_q - CW'(1));
    assign set_done    = (trig_cnt_q + 9'd1) == (9'd1 << eff_shift_q);
    assign total_words = {eff_cycles_q, 2'b00};
    assign word_fire   = m_tvalid_q && m_axis_tready;
    assign last_word   = word_fire && (ld_k_q == total_words) && (state_q == S_READOUT);

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (ctl_rise[0]) state_d = S_CAPTURE;
            S_CAPTURE: if (last_beat)   state_d = set_done ? S_READOUT : S_IDLE;
            S_READOUT: if (last_word)   state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state_q == S_CAPTURE);
    end

    // prime_q waits one cycle so rd_q holds row 0 including the final capture write
    assign ld     = (state_q == S_READOUT) && prime_q && (ld_k_q != total_words)
                    && (!m_tvalid_q || m_axis_tready);
    assign ld_k_d = ld_k_q + KW'(ld);

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            beat_idx_q   <= '0;
            trig_cnt_q   <= '0;
            eff_cycles_q <= CW'(1);
            eff_shift_q  <= '0;
            ld_k_q       <= '0;
            prime_q      <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            acc_vld_q    <= 1'b0;
            acc_first_q  <= 1'b0;
            acc_idx_q    <= '0;
            acc_data_q   <= '0;
        end else begin
            acc_vld_q   <= beat_fire;
            acc_first_q <= (trig_cnt_q == '0);
            acc_idx_q   <= beat_idx_q;
            acc_data_q  <= s_axis_tdata;
            if (state_q == S_IDLE && ctl_rise[0]) begin
                beat_idx_q <= '0;
                if (trig_cnt_q == '0) begin
                    eff_cycles_q <= eff_cycles_cfg;
                    eff_shift_q  <= eff_shift_cfg;
                end
            end
            if (beat_fire) beat_idx_q <= beat_idx_q + AW'(1);
            if (last_beat) trig_cnt_q <= trig_cnt_q + 9'd1;
            ld_k_q  <= (state_q == S_READOUT) ? ld_k_d : '0;
            prime_q <= (state_q == S_READOUT) && !last_word;
            if (ld) begin
                m_tdata_q  <= out_word;
                m_tvalid_q <= 1'b1;
            end else if (word_fire) begin
                m_tvalid_q <= 1'b0;
            end
            if (last_word) trig_cnt_q <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic signed [15:0] smp;
            logic signed [23:0] smp_ext, lane_val;
            assign smp      = acc_data_q[16*gi +: 16];
            assign smp_ext  = {{8{smp[15]}}, smp};
            assign lane_val = rd_q[24*gi +: 24];
            assign wr_row[24*gi +: 24] = acc_first_q ? smp_ext : lane_val + smp_ext;
            assign lane_avg[gi] = 16'(lane_val >>> eff_shift_q);
        end
    endgenerate

    assign out_word = {lane_avg[{ld_k_q[1:0], 1'b1}], lane_avg[{ld_k_q[1:0], 1'b0}]};
    assign rd_addr  = (state_q == S_CAPTURE) ? beat_idx_q : ld_k_d[KW-2:2];

    // Write-first forwarding lets the readout see the last accumulated beat immediately
    always_ff @(posedge pl_clk) begin
        if (acc_vld_q) mem[acc_idx_q] <= wr_row;
        rd_q <= (acc_vld_q && acc_idx_q == rd_addr) ? wr_row : mem[rd_addr];
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
endmodule

// File: tb/tb_adc_capture_driver.sv
// Randomized bench for adc_capture_driver against a sum-and-shift reference model.
module tb_adc_capture_driver;
    logic         pl_clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  gpio_ctrl = '0;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         select_in = 1'b0;

    int total = 0;
    int bad = 0;
    int m_run = 1;
    int m_shift = 0;
    int acc [16][8];
    logic [31:0] exp_q [$];
    logic [31:0] got_w [$];

    adc_capture_driver dut (
        .pl_clk(pl_clk), .rst(rst), .gpio_ctrl(gpio_ctrl),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .select_in(select_in)
    );

    always #5 pl_clk = ~pl_clk;

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pl_clk);
        #1;
    endtask

    function automatic int eff_cycles(input int r);
        if (r == 0) return 1;
        if (r > 16) return 16;
        return r;
    endfunction

    function automatic int eff_shift(input int s);
        return (s > 8) ? 8 : s;
    endfunction

    task automatic cfg_write(input int which, input logic [15:0] val, input bit sel);
        int clkbit;
        clkbit = (which == 0) ? 2 : 3;
        select_in = sel;
        for (int b = 0; b < 16; b++) begin
            gpio_ctrl[1] = val[b];
            wait_cyc(3);
            gpio_ctrl[clkbit] = 1'b1;
            wait_cyc(3);
            gpio_ctrl[clkbit] = 1'b0;
            wait_cyc(3);
        end
        wait_cyc(3);
        if (sel) begin
            if (which == 0) m_run = int'(val);
            else            m_shift = int'(val);
        end
    endtask

    function automatic logic [127:0] gen(input int mode, input int tidx);
        logic [127:0] d;
        case (mode)
            1:       d = 128'h8000_7000_6000_5000_4000_3000_2000_1000;
            2:       d = (tidx % 2 == 0) ? {8{16'h7FFF}} : {8{16'h8001}};
            default: d = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return d;
    endfunction

    task automatic do_trigger(input int ec, input int mode, input int tidx, input bit stall);
        int cnt = 0;
        int k = 0;
        int guard = 0;
        bit v;
        logic [127:0] d;
        gpio_ctrl[0] = 1'b1;
        do begin
            wait_cyc(1);
            cnt++;
        end while (!s_axis_tready && cnt < 20);
        check("trig_lat", cnt, 3);
        gpio_ctrl[0] = 1'b0;
        while (k < ec && guard < 500) begin
            v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = gen(mode, tidx);
            s_axis_tvalid = v;
            s_axis_tdata = d;
            wait_cyc(1);
            guard++;
            if (v) begin
                for (int l = 0; l < 8; l++) begin
                    int s;
                    s = int'($signed(d[16*l +: 16]));
                    acc[k][l] = (tidx == 0) ? s : acc[k][l] + s;
                end
                k++;
            end
        end
        s_axis_tvalid = 1'b0;
        check("tready_drop", s_axis_tready, 0);
    endtask

    task automatic collect(input bit bp);
        int n;
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        n = exp_q.size();
        got_w.delete();
        while (got < n && cyc < 3000) begin
            if (stalled) check("stall_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, held});
            stalled = 0;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    check($sformatf("word%0d", got), m_axis_tdata, exp_q[got]);
                    got_w.push_back(m_axis_tdata);
                    got++;
                end else begin
                    stalled = 1;
                    held = m_axis_tdata;
                end
            end
            wait_cyc(1);
            cyc++;
        end
        check("word_count", got, n);
        check("tvalid_drop", m_axis_tvalid, 0);
        m_axis_tready = 1'b0;
    endtask

    task automatic run_set(input int mode, input bit stall, input bit bp, input int gap,
                           input int new_shift);
        int ec, es, nt;
        ec = eff_cycles(m_run);
        es = eff_shift(m_shift);
        nt = 1 << es;
        for (int t = 0; t < nt; t++) begin
            do_trigger(ec, mode, t, stall);
            if (t < nt - 1) begin
                wait_cyc(gap);
                check("no_early", m_axis_tvalid, 0);
            end
        end
        exp_q.delete();
        for (int k = 0; k < 4 * ec; k++) begin
            int lo, hi;
            lo = acc[k/4][2*(k%4)] >>> es;
            hi = acc[k/4][2*(k%4)+1] >>> es;
            exp_q.push_back({hi[15:0], lo[15:0]});
        end
        if (new_shift >= 0) begin
            fork
                collect(bp);
                cfg_write(1, 16'(new_shift), 1'b1);
            join
        end else begin
            collect(bp);
        end
        wait_cyc(5);
        check("idle_after", m_axis_tvalid, 0);
        $display("set mode=%0d cycles=%0d shift=%0d triggers=%0d words=%0d",
                 mode, ec, es, nt, got_w.size());
    endtask

    initial begin
        wait_cyc(3);
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        rst = 1'b1;
        wait_cyc(3);

        // serial config, random data with input stalls and output backpressure
        cfg_write(0, 16'd4, 1'b1);
        cfg_write(1, 16'd2, 1'b1);
        run_set(0, 1'b1, 1'b1, 8, -1);

        // writes with select low are ignored; constant-input average
        cfg_write(0, 16'd9, 1'b0);
        cfg_write(1, 16'd5, 1'b0);
        run_set(1, 1'b0, 1'b0, 50, -1);
        check("const_words", got_w.size(), 16);
        check("const_w0", got_w[0], 32'h2000_1000);
        check("const_w3", got_w[3], 32'h8000_7000);

        // signed averaging cancels to zero
        cfg_write(1, 16'd1, 1'b1);
        run_set(2, 1'b0, 1'b1, 8, -1);
        check("signed_w0", got_w[0], 0);

        // shift rewritten during readout only affects the following set
        cfg_write(1, 16'd2, 1'b1);
        run_set(0, 1'b1, 1'b1, 8, 0);
        run_set(0, 1'b1, 1'b1, 8, -1);

        // clamp boundaries: cycles 0 -> 1 with shift 9 -> 8, cycles 20 -> 16
        cfg_write(0, 16'd0, 1'b1);
        cfg_write(1, 16'd9, 1'b1);
        run_set(0, 1'b1, 1'b0, 4, -1);
        cfg_write(0, 16'd20, 1'b1);
        cfg_write(1, 16'd1, 1'b1);
        run_set(0, 1'b1, 1'b1, 8, -1);

        // reset during capture
        cfg_write(0, 16'd4, 1'b1);
        cfg_write(1, 16'd1, 1'b1);
        gpio_ctrl[0] = 1'b1;
        for (int i = 0; i < 20 && !s_axis_tready; i++) wait_cyc(1);
        check("mid_capture", s_axis_tready, 1);
        gpio_ctrl[0] = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = gen(0, 0);
        wait_cyc(2);
        s_axis_tvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_tready", s_axis_tready, 0);
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tdata", m_axis_tdata, 0);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(3);
        m_run = 1;
        m_shift = 0;
        run_set(0, 1'b1, 1'b1, 8, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_capture_driver.md
# adc_capture_driver

Triggered capture-and-average engine between the RFSoC ADC AXI-Stream output and the CPU readout stream. On each trigger it captures a programmed number of 128-bit ADC beats (eight signed 16-bit samples each) and accumulates them sample-wise over 2^shift_val triggers. It then streams the averaged record to the CPU as 32-bit words. Configuration arrives bit-serially over the GPIO control word from the system controller.

## Interface
- MEM_DEPTH, 16: maximum record length in 128-bit beats.
- CFG_W, 16: width of the serial configuration registers.
- TRIG_BIT, 0: gpio_ctrl bit used as the trigger.
- SDATA_BIT, 1: gpio_ctrl bit carrying serial configuration data.
- CYC_CLK_BIT, 2: gpio_ctrl bit that clocks data into run_cycles.
- SHIFT_CLK_BIT, 3: gpio_ctrl bit that clocks data into shift_val.

Ports:
- pl_clk  in  1  single clock; all logic is in this domain.
- rst  in  1  asynchronous, active-low reset.
- gpio_ctrl  in  16  control lines; asynchronous to the block, synchronized internally.
- s_axis_tdata  in  128  ADC beat; sample i occupies bits [16i+15:16i], signed.
- s_axis_tvalid  in  1  ADC beat valid.
- s_axis_tready  out  1  high only in CAPTURE.
- m_axis_tdata  out  32  readout word.
- m_axis_tvalid  out  1  readout word valid.
- m_axis_tready  in  1  CPU accepts word.
- select_in  in  1  enables the serial configuration clocks.

## Operation
- Synchronization: gpio_ctrl and select_in pass through a 2-flop synchronizer. Rising edges are detected on the synchronized copies.
- Config write: on a rising edge of bit CYC_CLK_BIT (or SHIFT_CLK_BIT) while select_in is high:
  - run_cycles (or shift_val) <= {sdata, reg[CFG_W-1:1]}.
  - Data is sent LSB first, so after CFG_W clocks the register holds the sent value.
  - With select_in low, clock edges are ignored.
- Reset values: run_cycles = 1, shift_val = 0.
- Effective values:
  - eff_cycles = clamp(run_cycles, 1, MEM_DEPTH); 0 counts as 1.
  - eff_shift = min(shift_val, 8).
  - Both are latched on the first trigger of an averaging set.
  - Config writes during a set or during READOUT do not affect the current record.
- Accumulator memory: MEM_DEPTH × 8 signed 24-bit entries.
- State machine:
  - IDLE: a trigger rising edge -> CAPTURE. beat_idx = 0. If trig_cnt = 0, latch eff_cycles and eff_shift.
  - CAPTURE: s_axis_tready = 1. Each tvalid&tready beat updates entry [beat_idx][i]:
    - if trig_cnt = 0: entry = sext(sample_i);
    - otherwise: entry = entry + sext(sample_i).
    - After beat eff_cycles-1: trig_cnt++. If trig_cnt reaches 2^eff_shift -> READOUT, else -> IDLE.
    - Triggers received during CAPTURE are ignored.
  - READOUT: streams eff_cycles*4 words.
    - Word k = {avg[2k+1], avg[2k]}, where avg[n] = (entry[n/8][n%8] >>> eff_shift)[15:0], an arithmetic shift truncated to 16 bits.
    - A word advances on m_axis_tvalid & m_axis_tready.
    - After the last word is accepted -> IDLE with trig_cnt = 0.
    - Triggers received during READOUT are ignored.

## Timing
- Trigger edge to s_axis_tready high: 3 pl_clk cycles (2 sync + 1 edge register).
- Last capture beat to m_axis_tvalid high: at most 2 cycles.
- The first word is held stable until accepted.
- Readout rate: one word per cycle while m_axis_tready is held high. m_axis_tvalid and m_axis_tdata must not change while tvalid=1 and tready=0.
- m_axis_tvalid drops the cycle after the final handshake.
- Reset asserted mid-operation: immediately go to IDLE. Clear trig_cnt, run_cycles, shift_val, m_axis_tvalid, m_axis_tdata (0) and s_axis_tready (0). Memory contents are don't-care.
- s_axis_tvalid low during CAPTURE: stall without advancing beat_idx.

## Test plan
- Serial config: with select_in = 1, shift in 4 on CYC_CLK_BIT and 2 on SHIFT_CLK_BIT. The next set captures 4 beats per trigger over 4 triggers. Repeat with select_in = 0: the registers are unchanged.
- Constant-input average: tdata = {8000,7000,…,1000 hex}, run_cycles = 4, shift = 2, 4 triggers spaced 50 cycles apart, tready = 1.
  - Exactly 16 words are produced.
  - Word k = tdata[32(k%4)+:32], e.g. word 0 = 0x20001000, word 3 = 0x80007000.
  - m_axis_tvalid is 0 afterwards.
- Signed averaging: alternate triggers with sample values 0x7FFF and 0x8001, shift = 1. Every averaged sample = 0x0000.
- Backpressure: toggle m_axis_tready randomly. No word is lost or duplicated, and tdata stays stable while stalled.
- Config during readout: write shift = 0 after the 4th trigger. The record is still divided by 4, and the following set uses a single trigger.
- Reset mid-capture: pull rst low during CAPTURE. Outputs return to 0, and the next trigger starts a fresh set with run_cycles = 1.
